sprite_compositor: RTL and testbench

//  Parametrised N-layer sprite compositor between the VGA timing controller and the DAC pins.

---
 rtl/sprite_compositor.sv | 179 +++++++++++++++++
 tb/tb_sprite_compositor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor: N-layer sprite compositor between VGA timing and the DAC pins.
// Two-stage pipeline: stage 1 registers per-sprite local coordinates and window hits,
// stage 2 picks the highest-priority opaque sprite (index 0 first) over the background.
// Sprite positions are double-buffered; the active bank only changes at frame_start.
// Optional feature macro: SPRITE_COLLISION_EN (per-frame opaque-overlap flags).
module sprite_compositor #(
  parameter int NUM_SPRITES = 2,
  parameter int CW          = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        pix_valid_i,
  input  logic [CW-1:0]               pix_x_i,
  input  logic [CW-1:0]               pix_y_i,
  input  logic                        frame_start_i,
  input  logic                        spr_upd_i,
  input  logic [NUM_SPRITES*CW-1:0]   spr_x_i,
  input  logic [NUM_SPRITES*CW-1:0]   spr_y_i,
  input  logic [NUM_SPRITES-1:0]      spr_en_i,
  input  logic [NUM_SPRITES*CW-1:0]   spr_w_i,
  input  logic [NUM_SPRITES*CW-1:0]   spr_h_i,
  output logic [NUM_SPRITES*CW-1:0]   spr_lx_o,
  output logic [NUM_SPRITES*CW-1:0]   spr_ly_o,
  input  logic [NUM_SPRITES*24-1:0]   spr_rgb_i,
  input  logic [NUM_SPRITES-1:0]      spr_a_i,
  input  logic [23:0]                 bg_rgb_i,
  output logic [23:0]                 rgb_out_o,
  output logic                        rgb_valid_o,
  output logic [NUM_SPRITES-1:0]      coll_flags_o
);

  localparam int N = NUM_SPRITES;

  // Position banks
  logic [N*CW-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [N-1:0]    pend_en_q, pend_en_d;
  logic            pend_flag_q, pend_flag_d;
  logic [N*CW-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [N-1:0]    act_en_q, act_en_d;

  // Stage 1
  logic [N*CW-1:0] lx_q, lx_d, ly_q, ly_d;
  logic [N-1:0]    hit_q, hit_d;
  logic            v1_q;

  // Stage 2
  logic [N-1:0]    opaque;
  logic [23:0]     sel_rgb;
  logic [23:0]     rgb_q, rgb_d;
  logic            valid_q;

  // Bank update: an update coinciding with frame_start bypasses the pending bank.
  always_comb begin
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_en_d   = pend_en_q;
    pend_flag_d = pend_flag_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    act_en_d    = act_en_q;
    if (spr_upd_i && frame_start_i) begin
      pend_x_d    = spr_x_i;
      pend_y_d    = spr_y_i;
      pend_en_d   = spr_en_i;
      act_x_d     = spr_x_i;
      act_y_d     = spr_y_i;
      act_en_d    = spr_en_i;
      pend_flag_d = 1'b0;
    end else if (spr_upd_i) begin
      pend_x_d    = spr_x_i;
      pend_y_d    = spr_y_i;
      pend_en_d   = spr_en_i;
      pend_flag_d = 1'b1;
    end else if (frame_start_i && pend_flag_q) begin
      act_x_d     = pend_x_q;
      act_y_d     = pend_y_q;
      act_en_d    = pend_en_q;
      pend_flag_d = 1'b0;
    end
  end

  // Stage 1: local coordinates (mod 2^CW) and window hit, end computed in CW+1 bits to avoid wrap.
  always_comb begin
    lx_d  = '0;
    ly_d  = '0;
    hit_d = '0;
    for (int i = 0; i < N; i++) begin
      lx_d[i*CW +: CW] = pix_x_i - act_x_q[i*CW +: CW];
      ly_d[i*CW +: CW] = pix_y_i - act_y_q[i*CW +: CW];
      hit_d[i] = act_en_q[i]
               & (pix_x_i >= act_x_q[i*CW +: CW])
               & ({1'b0, pix_x_i} < ({1'b0, act_x_q[i*CW +: CW]} + {1'b0, spr_w_i[i*CW +: CW]}))
               & (pix_y_i >= act_y_q[i*CW +: CW])
               & ({1'b0, pix_y_i} < ({1'b0, act_y_q[i*CW +: CW]} + {1'b0, spr_h_i[i*CW +: CW]}));
    end
  end

  // Stage 2: lowest-index opaque hit wins, background otherwise, black during blanking.
  always_comb begin
    opaque  = hit_q & spr_a_i;
    sel_rgb = bg_rgb_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (opaque[i]) sel_rgb = spr_rgb_i[i*24 +: 24];
    end
    rgb_d = v1_q ? sel_rgb : 24'h0;
  end

  // Pipeline and bank registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_en_q   <= '0;
      pend_flag_q <= 1'b0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_en_q    <= '0;
      lx_q        <= '0;
      ly_q        <= '0;
      hit_q       <= '0;
      v1_q        <= 1'b0;
      rgb_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_en_q   <= pend_en_d;
      pend_flag_q <= pend_flag_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_en_q    <= act_en_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      hit_q       <= hit_d;
      v1_q        <= pix_valid_i;
      rgb_q       <= rgb_d;
      valid_q     <= v1_q;
    end
  end

  assign spr_lx_o    = lx_q;
  assign spr_ly_o    = ly_q;
  assign rgb_out_o   = rgb_q;
  assign rgb_valid_o = valid_q;

`ifdef SPRITE_COLLISION_EN
  logic [N-1:0] acc_q, acc_d, coll_q, coll_d;
  logic         multi;

  // Accumulate opaque overlaps; frame_start publishes and clears (clear beats a same-cycle set).
  always_comb begin
    multi  = |(opaque & (opaque - 1'b1));
    acc_d  = acc_q;
    coll_d = coll_q;
    if (frame_start_i) begin
      coll_d = acc_q;
      acc_d  = '0;
    end else if (v1_q && multi) begin
      acc_d = acc_q | opaque;
    end
  end

  // Collision registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      coll_q <= '0;
    end else begin
      acc_q  <= acc_d;
      coll_q <= coll_d;
    end
  end

  assign coll_flags_o = coll_q;
`else
  assign coll_flags_o = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: pixel-level reference model plus literal expectations.
module tb_sprite_compositor;
  localparam int N  = 2;
  localparam int CW = 10;
  localparam logic [23:0] BG = 24'h123456;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_valid, frame_start, spr_upd;
  logic [CW-1:0] pix_x, pix_y;
  logic [N*CW-1:0] spr_x, spr_y, spr_w, spr_h, spr_lx, spr_ly;
  logic [N-1:0] spr_en, spr_a, coll_flags;
  logic [N*24-1:0] spr_rgb;
  logic [23:0] bg_rgb, rgb_out;
  logic rgb_valid;

  logic [CW-1:0] in_x [N], in_y [N], in_w [N], in_h [N];
  logic          in_en [N];
  logic transp, bg_vary;
  int cyc, checks, failures;

  // model state
  logic [CW-1:0] ax [N], ay [N], px [N], py [N], s1_lx [N], s1_ly [N];
  logic          aen [N], pen [N];
  logic pflag, s1_v, s1_has, m_valid;
  logic [23:0] s1_col, m_rgb;
  logic [N-1:0] s1_mask, m_acc, m_coll;

  always #5 clk = ~clk;

  sprite_compositor #(.NUM_SPRITES(N), .CW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_valid_i(pix_valid), .pix_x_i(pix_x), .pix_y_i(pix_y),
    .frame_start_i(frame_start), .spr_upd_i(spr_upd), .spr_x_i(spr_x), .spr_y_i(spr_y),
    .spr_en_i(spr_en), .spr_w_i(spr_w), .spr_h_i(spr_h), .spr_lx_o(spr_lx), .spr_ly_o(spr_ly),
    .spr_rgb_i(spr_rgb), .spr_a_i(spr_a), .bg_rgb_i(bg_rgb), .rgb_out_o(rgb_out),
    .rgb_valid_o(rgb_valid), .coll_flags_o(coll_flags));

  function automatic logic [23:0] colour(input int i, input logic [CW-1:0] lx, input logic [CW-1:0] ly);
    return {8'((i + 1) * 64), lx[7:0], ly[7:0]};
  endfunction

  function automatic logic alpha(input int i, input logic [CW-1:0] lx, input logic [CW-1:0] ly);
    return !(transp && i == 0 && lx == 3 && ly == 3);
  endfunction

  // Image modules: combinational lookup from the DUT's local coordinates.
  always_comb begin
    spr_rgb = '0;
    spr_a   = '0;
    for (int i = 0; i < N; i++) begin
      spr_rgb[i*24 +: 24] = colour(i, spr_lx[i*CW +: CW], spr_ly[i*CW +: CW]);
      spr_a[i] = alpha(i, spr_lx[i*CW +: CW], spr_ly[i*CW +: CW]);
    end
  end

  // Sprite configuration busses.
  always_comb begin
    spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_en = '0;
    for (int i = 0; i < N; i++) begin
      spr_x[i*CW +: CW] = in_x[i];
      spr_y[i*CW +: CW] = in_y[i];
      spr_w[i*CW +: CW] = in_w[i];
      spr_h[i*CW +: CW] = in_h[i];
      spr_en[i] = in_en[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h time=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ax[i] = '0; ay[i] = '0; aen[i] = 1'b0; px[i] = '0; py[i] = '0; pen[i] = 1'b0;
      s1_lx[i] = '0; s1_ly[i] = '0;
    end
    pflag = 1'b0; s1_v = 1'b0; s1_has = 1'b0; s1_col = '0; s1_mask = '0;
    m_valid = 1'b0; m_rgb = '0; m_acc = '0; m_coll = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [N-1:0] set, mask;
    logic has;
    logic [23:0] col;
    if (!rst_n) begin
      model_reset();
    end else begin
      set = '0;
      if (s1_v && $countones(s1_mask) >= 2) set = s1_mask;
      m_valid = s1_v;
      m_rgb = s1_v ? (s1_has ? s1_col : bg_rgb) : 24'h0;
      has = 1'b0; col = '0; mask = '0;
      for (int i = 0; i < N; i++) begin
        s1_lx[i] = pix_x - ax[i];
        s1_ly[i] = pix_y - ay[i];
        if (aen[i] && int'(pix_x) >= int'(ax[i]) && int'(pix_x) < int'(ax[i]) + int'(in_w[i])
            && int'(pix_y) >= int'(ay[i]) && int'(pix_y) < int'(ay[i]) + int'(in_h[i])
            && alpha(i, s1_lx[i], s1_ly[i])) begin
          mask[i] = 1'b1;
          if (!has) begin has = 1'b1; col = colour(i, s1_lx[i], s1_ly[i]); end
        end
      end
      s1_v = pix_valid; s1_has = has; s1_col = col; s1_mask = mask;
`ifdef SPRITE_COLLISION_EN
      if (frame_start) begin m_coll = m_acc; m_acc = '0; end
      else m_acc = m_acc | set;
`endif
      if (spr_upd && frame_start) begin
        for (int i = 0; i < N; i++) begin ax[i] = in_x[i]; ay[i] = in_y[i]; aen[i] = in_en[i]; end
        pflag = 1'b0;
      end else if (spr_upd) begin
        for (int i = 0; i < N; i++) begin px[i] = in_x[i]; py[i] = in_y[i]; pen[i] = in_en[i]; end
        pflag = 1'b1;
      end else if (frame_start && pflag) begin
        for (int i = 0; i < N; i++) begin ax[i] = px[i]; ay[i] = py[i]; aen[i] = pen[i]; end
        pflag = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("rgb_valid", 32'(rgb_valid), 32'(m_valid));
    chk("rgb_out", 32'(rgb_out), 32'(m_rgb));
    chk("coll_flags", 32'(coll_flags), 32'(m_coll));
    if (s1_v) begin
      for (int i = 0; i < N; i++) begin
        chk("spr_lx", 32'(spr_lx[i*CW +: CW]), 32'(s1_lx[i]));
        chk("spr_ly", 32'(spr_ly[i*CW +: CW]), 32'(s1_ly[i]));
      end
    end
  endtask

  // One clock: check at the falling edge, apply inputs, advance model, step to next falling edge.
  task automatic tick(input logic v, input int x, input int y, input logic fs, input logic upd);
    check_outputs();
    pix_valid = v; pix_x = CW'(x); pix_y = CW'(y); frame_start = fs; spr_upd = upd;
    bg_rgb = bg_vary ? (24'hC00000 | 24'(cyc & 32'hFFFF)) : BG;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic pix_lit(input string name, input int x, input int y, input logic [23:0] exp);
    tick(1'b1, x, y, 1'b0, 1'b0);
    tick(1'b0, 0, 0, 1'b0, 1'b0);
    chk(name, 32'(rgb_out), 32'(exp));
    chk({name, "_valid"}, 32'(rgb_valid), 32'd1);
  endtask

  task automatic set_spr(input int i, input int x, input int y, input logic en);
    in_x[i] = CW'(x); in_y[i] = CW'(y); in_en[i] = en;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; frame_start = 1'b0; spr_upd = 1'b0;
    bg_rgb = BG; transp = 1'b0; bg_vary = 1'b0;
    for (int i = 0; i < N; i++) begin set_spr(i, 0, 0, 1'b0); in_w[i] = 10'd32; in_h[i] = 10'd32; end
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(rgb_out), 32'd0);
    chk("reset_valid", 32'(rgb_valid), 32'd0);
    chk("reset_lx", 32'(spr_lx), 32'd0);
    chk("reset_ly", 32'(spr_ly), 32'd0);
    chk("reset_coll", 32'(coll_flags), 32'd0);
    rst_n = 1'b1;

    // background only, varying bg, with blanking gaps
    bg_vary = 1'b1;
    for (int x = 0; x < 640; x++) tick(1'b1, x, 0, 1'b0, 1'b0);
    idle(4);
    for (int x = 0; x < 640; x++) tick(1'b1, x, 479, 1'b0, 1'b0);
    idle(4);
    for (int x = 0; x < 48; x++) tick((x % 3) != 0, x, 240, 1'b0, 1'b0);
    idle(3);
    bg_vary = 1'b0;

    // single opaque sprite at (100,50)
    set_spr(0, 100, 50, 1'b1);
    tick(1'b0, 0, 0, 1'b1, 1'b1);
    idle(2);
    tick(1'b1, 100, 50, 1'b0, 1'b0);
    chk("t2_lx0", 32'(spr_lx[0 +: CW]), 32'd0);
    chk("t2_ly0", 32'(spr_ly[0 +: CW]), 32'd0);
    tick(1'b0, 0, 0, 1'b0, 1'b0);
    chk("t2_origin", 32'(rgb_out), 32'h400000);
    pix_lit("t2_corner", 131, 81, 24'h401F1F);
    pix_lit("t2_right", 132, 50, BG);
    pix_lit("t2_left", 99, 50, BG);
    pix_lit("t2_below", 100, 82, BG);
    for (int x = 90; x < 140; x++) tick(1'b1, x, 60, 1'b0, 1'b0);
    idle(3);

    // overlap with a transparent hole in sprite 0
    set_spr(0, 200, 200, 1'b1); set_spr(1, 200, 200, 1'b1); transp = 1'b1;
    tick(1'b0, 0, 0, 1'b1, 1'b1);
    idle(2);
    pix_lit("t3_hole", 203, 203, 24'h800303);
    pix_lit("t3_front", 204, 203, 24'h400403);
    for (int y = 200; y < 206; y++)
      for (int x = 198; x < 208; x++) tick(1'b1, x, y, 1'b0, 1'b0);
    idle(3);
    transp = 1'b0;

    // double buffering
    set_spr(0, 100, 50, 1'b1); set_spr(1, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b1, 1'b1);
    pix_lit("t4_before", 100, 50, 24'h400000);
    set_spr(0, 300, 50, 1'b1);
    tick(1'b0, 0, 0, 1'b0, 1'b1);
    pix_lit("t4_hold_old", 100, 50, 24'h400000);
    pix_lit("t4_hold_new", 300, 50, BG);
    tick(1'b0, 0, 0, 1'b1, 1'b0);
    pix_lit("t4_commit_new", 300, 50, 24'h400000);
    pix_lit("t4_commit_old", 100, 50, BG);
    set_spr(0, 400, 50, 1'b1);
    tick(1'b0, 0, 0, 1'b1, 1'b1);
    pix_lit("t4_coincident", 400, 50, 24'h400000);
    set_spr(0, 500, 50, 1'b1); tick(1'b0, 0, 0, 1'b0, 1'b1);
    set_spr(0, 600, 50, 1'b1); tick(1'b0, 0, 0, 1'b0, 1'b1);
    tick(1'b0, 0, 0, 1'b1, 1'b0);
    pix_lit("t4_last_wins", 600, 50, 24'h400000);
    pix_lit("t4_first_lost", 500, 50, BG);
    tick(1'b0, 0, 0, 1'b1, 1'b0);
    pix_lit("t4_fs_no_pending", 600, 50, 24'h400000);

    // right-edge sprite without wrap; zero-width and zero-height sprite 1
    in_w[0] = 10'd64; set_spr(0, 1000, 0, 1'b1);
    in_w[1] = 10'd0; set_spr(1, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 1'b1, 1'b1);
    for (int x = 995; x < 1024; x++) tick(1'b1, x, 0, 1'b0, 1'b0);
    for (int x = 0; x < 8; x++) tick(1'b1, x, 0, 1'b0, 1'b0);
    idle(2);
    pix_lit("t5_last", 1023, 0, 24'h401700);
    pix_lit("t5_first", 1000, 0, 24'h400000);
    pix_lit("t5_before", 999, 0, BG);
    pix_lit("t5_nowrap", 5, 0, BG);
    pix_lit("t5_zero_w", 0, 0, BG);
    in_w[1] = 10'd8; in_h[1] = 10'd0;
    pix_lit("t5_zero_h", 0, 0, BG);
    in_w[0] = 10'd32; in_w[1] = 10'd32; in_h[1] = 10'd32;

    // reset in the middle of a line
    set_spr(0, 100, 50, 1'b1); set_spr(1, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b1, 1'b1);
    tick(1'b1, 100, 50, 1'b0, 1'b0);
    tick(1'b1, 101, 50, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(rgb_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rgb_valid), 32'd0);
    chk("rst_async_rgb", 32'(rgb_out), 32'd0);
    chk("rst_async_lx", 32'(spr_lx), 32'd0);
    model_reset();
    @(negedge clk);
    tick(1'b1, 102, 50, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 0, 0, 1'b0, 1'b0);
    pix_lit("rst_bank_cleared", 100, 50, BG);

    // collision flags
    set_spr(0, 200, 200, 1'b1); set_spr(1, 200, 200, 1'b1);
    tick(1'b0, 0, 0, 1'b1, 1'b1);
    idle(2);
    tick(1'b0, 0, 0, 1'b1, 1'b0);
    tick(1'b1, 205, 205, 1'b0, 1'b0);
    idle(3);
    set_spr(1, 500, 400, 1'b1);
    tick(1'b0, 0, 0, 1'b1, 1'b1);
`ifdef SPRITE_COLLISION_EN
    chk("t6_flags_set", 32'(coll_flags), 32'd3);
`else
    chk("t6_flags_tied", 32'(coll_flags), 32'd0);
`endif
    tick(1'b1, 205, 205, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t6_flags_clear", 32'(coll_flags), 32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
